// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ops, captures missing operands from the CDB,
// and dispatches the lowest-index operand-ready entry each cycle onto registered ALU outputs.
`timescale 1ns/1ps
module alu_reservation_station #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [PC_W-1:0]   issue_pc,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [TAG_W-1:0]  issue_dest,
    input  logic              issue_q1_busy,
    input  logic              issue_q2_busy,
    input  logic [TAG_W-1:0]  issue_q1,
    input  logic [TAG_W-1:0]  issue_q2,
    input  logic [DATA_W-1:0] issue_v1,
    input  logic [DATA_W-1:0] issue_v2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              full,
    output logic              is_empty_to_alu,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [PC_W-1:0]   pc_to_alu,
    output logic [TAG_W-1:0]  dest_to_alu
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  dest;
        logic              q1_busy;
        logic [TAG_W-1:0]  q1;
        logic [DATA_W-1:0] v1;
        logic              q2_busy;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] v2;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            new_ent;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] v1_q, v1_d, v2_q, v2_d, imm_q, imm_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [TAG_W-1:0]  dest_q, dest_d;
    logic              alloc_found, disp_found;
    logic [IDX_W-1:0]  alloc_idx, disp_idx;
    logic [CNT_W-1:0]  cnt;

    // Incoming entry with same-cycle CDB bypass on each busy source
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.op      = issue_op;
        new_ent.pc      = issue_pc;
        new_ent.imm     = issue_imm;
        new_ent.dest    = issue_dest;
        new_ent.q1      = issue_q1;
        new_ent.q2      = issue_q2;
        new_ent.q1_busy = issue_q1_busy;
        new_ent.q2_busy = issue_q2_busy;
        new_ent.v1      = issue_v1;
        new_ent.v2      = issue_v2;
        if (cdb_valid && issue_q1_busy && (cdb_tag == issue_q1)) begin
            new_ent.q1_busy = 1'b0;
            new_ent.v1      = cdb_data;
        end
        if (cdb_valid && issue_q2_busy && (cdb_tag == issue_q2)) begin
            new_ent.q2_busy = 1'b0;
            new_ent.v2      = cdb_data;
        end
    end

    // Free-slot and ready-entry search on registered state, lowest index wins
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        disp_found  = 1'b0;
        disp_idx    = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (ent_q[i].valid && !ent_q[i].q1_busy && !ent_q[i].q2_busy) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ent_d   = ent_q;
        empty_d = 1'b1;
        op_d    = op_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        dest_d  = dest_q;
        cnt     = '0;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_d[i].valid = 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_q[i].valid && cdb_valid) begin
                    if (ent_q[i].q1_busy && (ent_q[i].q1 == cdb_tag)) begin
                        ent_d[i].q1_busy = 1'b0;
                        ent_d[i].v1      = cdb_data;
                    end
                    if (ent_q[i].q2_busy && (ent_q[i].q2 == cdb_tag)) begin
                        ent_d[i].q2_busy = 1'b0;
                        ent_d[i].v2      = cdb_data;
                    end
                end
            end
            if (disp_found) begin
                empty_d                = 1'b0;
                op_d                   = ent_q[disp_idx].op;
                v1_d                   = ent_q[disp_idx].v1;
                v2_d                   = ent_q[disp_idx].v2;
                imm_d                  = ent_q[disp_idx].imm;
                pc_d                   = ent_q[disp_idx].pc;
                dest_d                 = ent_q[disp_idx].dest;
                ent_d[disp_idx].valid  = 1'b0;
            end
            // Full is registered, so a slot freed by dispatch this cycle is not yet visible here
            if (issue_valid && !full_q && alloc_found) begin
                ent_d[alloc_idx] = new_ent;
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt = cnt + CNT_W'(ent_d[i].valid);
        end
        full_d = (cnt == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            op_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            dest_q  <= '0;
        end else begin
            ent_q   <= ent_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            op_q    <= op_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            dest_q  <= dest_d;
        end
    end

    assign full            = full_q;
    assign is_empty_to_alu = empty_q;
    assign op_to_alu       = op_q;
    assign v1_to_alu       = v1_q;
    assign v2_to_alu       = v2_q;
    assign imm_to_alu      = imm_q;
    assign pc_to_alu       = pc_q;
    assign dest_to_alu     = dest_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed vector table, hand-written corner sequences,
// and random traffic checked against a slot-array reference model.
`timescale 1ns/1ps
module tb_alu_reservation_station;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned TAG_W  = 4;

    localparam logic [OP_W-1:0] ADD  = 6'h01;
    localparam logic [OP_W-1:0] SUB  = 6'h02;
    localparam logic [OP_W-1:0] ADDI = 6'h03;
    localparam logic [OP_W-1:0] BEQ  = 6'h10;

    logic              clk, rst, flush, issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic [PC_W-1:0]   issue_pc;
    logic [DATA_W-1:0] issue_imm, issue_v1, issue_v2, cdb_data;
    logic [TAG_W-1:0]  issue_dest, issue_q1, issue_q2, cdb_tag;
    logic              issue_q1_busy, issue_q2_busy, cdb_valid;
    logic              full, is_empty_to_alu;
    logic [OP_W-1:0]   op_to_alu;
    logic [DATA_W-1:0] v1_to_alu, v2_to_alu, imm_to_alu;
    logic [PC_W-1:0]   pc_to_alu;
    logic [TAG_W-1:0]  dest_to_alu;

    int checks = 0;
    int errors = 0;
    logic [PC_W-1:0] pc_ctr = 32'h1000;

    alu_reservation_station #(
        .DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W), .PC_W(PC_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_op(issue_op), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_dest(issue_dest), .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
        .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .full(full), .is_empty_to_alu(is_empty_to_alu), .op_to_alu(op_to_alu),
        .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu), .imm_to_alu(imm_to_alu),
        .pc_to_alu(pc_to_alu), .dest_to_alu(dest_to_alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per slot plus the expected registered outputs
    logic              m_valid [DEPTH];
    logic [OP_W-1:0]   m_op    [DEPTH];
    logic [PC_W-1:0]   m_pc    [DEPTH];
    logic [DATA_W-1:0] m_imm   [DEPTH];
    logic [TAG_W-1:0]  m_dest  [DEPTH];
    logic              m_b1    [DEPTH];
    logic              m_b2    [DEPTH];
    logic [TAG_W-1:0]  m_t1    [DEPTH];
    logic [TAG_W-1:0]  m_t2    [DEPTH];
    logic [DATA_W-1:0] m_v1    [DEPTH];
    logic [DATA_W-1:0] m_v2    [DEPTH];
    logic              e_full, e_empty;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_v1, e_v2, e_imm;
    logic [PC_W-1:0]   e_pc;
    logic [TAG_W-1:0]  e_dest;

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
        e_full = 1'b0; e_empty = 1'b1; e_op = '0; e_v1 = '0; e_v2 = '0;
        e_imm = '0; e_pc = '0; e_dest = '0;
    endtask

    task automatic model_step();
        int sel, fr, n;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
            e_empty = 1'b1;
            e_full  = 1'b0;
            return;
        end
        sel = -1;
        fr  = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sel < 0 && m_valid[i] && !m_b1[i] && !m_b2[i]) sel = i;
            if (fr < 0 && !m_valid[i]) fr = i;
        end
        if (sel >= 0) begin
            e_empty = 1'b0;
            e_op = m_op[sel]; e_v1 = m_v1[sel]; e_v2 = m_v2[sel];
            e_imm = m_imm[sel]; e_pc = m_pc[sel]; e_dest = m_dest[sel];
            m_valid[sel] = 1'b0;
        end else begin
            e_empty = 1'b1;
        end
        if (cdb_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (m_valid[i] && m_b1[i] && m_t1[i] == cdb_tag) begin m_b1[i] = 1'b0; m_v1[i] = cdb_data; end
                if (m_valid[i] && m_b2[i] && m_t2[i] == cdb_tag) begin m_b2[i] = 1'b0; m_v2[i] = cdb_data; end
            end
        end
        if (issue_valid && !e_full && fr >= 0) begin
            m_valid[fr] = 1'b1;
            m_op[fr] = issue_op; m_pc[fr] = issue_pc; m_imm[fr] = issue_imm; m_dest[fr] = issue_dest;
            m_t1[fr] = issue_q1; m_t2[fr] = issue_q2;
            m_b1[fr] = issue_q1_busy && !(cdb_valid && cdb_tag == issue_q1);
            m_b2[fr] = issue_q2_busy && !(cdb_valid && cdb_tag == issue_q2);
            m_v1[fr] = (issue_q1_busy && !m_b1[fr]) ? cdb_data : issue_v1;
            m_v2[fr] = (issue_q2_busy && !m_b2[fr]) ? cdb_data : issue_v2;
        end
        n = 0;
        for (int i = 0; i < int'(DEPTH); i++) n += int'(m_valid[i]);
        e_full = (n == int'(DEPTH));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("full", 64'(full), 64'(e_full));
        chk("is_empty", 64'(is_empty_to_alu), 64'(e_empty));
        chk("op", 64'(op_to_alu), 64'(e_op));
        chk("v1", 64'(v1_to_alu), 64'(e_v1));
        chk("v2", 64'(v2_to_alu), 64'(e_v2));
        chk("imm", 64'(imm_to_alu), 64'(e_imm));
        chk("pc", 64'(pc_to_alu), 64'(e_pc));
        chk("dest", 64'(dest_to_alu), 64'(e_dest));
    endtask

    // One clock: edge, model update with the held inputs, then sample 1ns later
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        flush = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        issue_op = '0; issue_pc = '0; issue_imm = '0; issue_dest = '0;
        issue_q1_busy = 1'b0; issue_q2_busy = 1'b0; issue_q1 = '0; issue_q2 = '0;
        issue_v1 = '0; issue_v2 = '0;
    endtask

    task automatic set_issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                             input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] imm,
                             input logic b1, input logic [TAG_W-1:0] q1,
                             input logic [TAG_W-1:0] dest);
        issue_valid = 1'b1; issue_op = op; issue_v1 = v1; issue_v2 = v2; issue_imm = imm;
        issue_q1_busy = b1; issue_q1 = q1; issue_q2_busy = 1'b0; issue_q2 = '0;
        issue_dest = dest; issue_pc = pc_ctr;
        pc_ctr += 4;
    endtask

    typedef struct {
        logic              iv;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] v1, v2, imm;
        logic              b1;
        logic [TAG_W-1:0]  q1, dest;
        logic              cv;
        logic [TAG_W-1:0]  ct;
        logic [DATA_W-1:0] cd;
        logic              x_empty;
        logic [OP_W-1:0]   x_op;
        logic [DATA_W-1:0] x_v1, x_v2, x_imm;
        logic [TAG_W-1:0]  x_dest;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                                input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] imm,
                                input logic b1, input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] dest,
                                input logic cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd,
                                input logic xe, input logic [OP_W-1:0] xop, input logic [DATA_W-1:0] xv1,
                                input logic [DATA_W-1:0] xv2, input logic [DATA_W-1:0] ximm,
                                input logic [TAG_W-1:0] xd);
        vec_t v;
        v.iv = iv; v.op = op; v.v1 = v1; v.v2 = v2; v.imm = imm; v.b1 = b1; v.q1 = q1; v.dest = dest;
        v.cv = cv; v.ct = ct; v.cd = cd;
        v.x_empty = xe; v.x_op = xop; v.x_v1 = xv1; v.x_v2 = xv2; v.x_imm = ximm; v.x_dest = xd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        tbl[0]  = mk(1, ADD,  5, 7, 0, 0, 0, 3,  0, 0, 0,        1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, SUB,  9, 4, 0, 0, 0, 4,  0, 0, 0,        0, ADD, 5, 7, 0, 3);
        tbl[2]  = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        0, SUB, 9, 4, 0, 4);
        tbl[3]  = mk(1, ADDI, 0, 0, 32'h10, 1, 6, 5, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0,    0, 0, 0, 0, 0, 0,  1, 6, 32'h20,   1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        0, ADDI, 32'h20, 0, 32'h10, 5);
        tbl[9]  = mk(1, BEQ,  0, 32'h33, 8, 1, 2, 7, 1, 2, 32'hAB, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        0, BEQ, 32'hAB, 32'h33, 8, 7);
        tbl[11] = mk(0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 0, 0, 0, 0, 0);

        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        #2 rst = 1'b1;

        // Directed vectors: back-to-back ready ops, CDB wakeup, issue-time bypass
        for (int k = 0; k < 12; k++) begin
            idle_inputs();
            if (tbl[k].iv)
                set_issue(tbl[k].op, tbl[k].v1, tbl[k].v2, tbl[k].imm, tbl[k].b1, tbl[k].q1, tbl[k].dest);
            cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; cdb_data = tbl[k].cd;
            step();
            chk($sformatf("vec%0d_empty", k), 64'(is_empty_to_alu), 64'(tbl[k].x_empty));
            if (!tbl[k].x_empty) begin
                chk($sformatf("vec%0d_op", k), 64'(op_to_alu), 64'(tbl[k].x_op));
                chk($sformatf("vec%0d_v1", k), 64'(v1_to_alu), 64'(tbl[k].x_v1));
                chk($sformatf("vec%0d_v2", k), 64'(v2_to_alu), 64'(tbl[k].x_v2));
                chk($sformatf("vec%0d_imm", k), 64'(imm_to_alu), 64'(tbl[k].x_imm));
                chk($sformatf("vec%0d_dest", k), 64'(dest_to_alu), 64'(tbl[k].x_dest));
            end
        end

        // Fill with never-ready entries; the ninth issue must be dropped
        for (int k = 0; k < 9; k++) begin
            idle_inputs();
            set_issue(ADD, 0, 32'(k), 0, 1'b1, 4'd15, 4'(k));
            step();
            chk($sformatf("fill%0d_full", k), 64'(full), 64'(k >= 7));
            chk($sformatf("fill%0d_empty", k), 64'(is_empty_to_alu), 64'd1);
        end
        idle_inputs();
        cdb_valid = 1'b1; cdb_tag = 4'd15; cdb_data = 32'd1;
        step();
        chk("bcast_edge_empty", 64'(is_empty_to_alu), 64'd1);
        chk("bcast_edge_full", 64'(full), 64'd1);
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("drain%0d_empty", k), 64'(is_empty_to_alu), 64'd0);
            chk($sformatf("drain%0d_dest", k), 64'(dest_to_alu), 64'(k));
            chk($sformatf("drain%0d_v1", k), 64'(v1_to_alu), 64'd1);
            chk($sformatf("drain%0d_full", k), 64'(full), 64'd0);
        end
        step();
        chk("drain_done_empty", 64'(is_empty_to_alu), 64'd1);

        // Flush with issue and matching broadcast in the same cycle
        idle_inputs(); set_issue(SUB, 1, 2, 0, 1'b1, 4'd9, 4'd1); step();
        idle_inputs(); set_issue(SUB, 3, 4, 0, 1'b1, 4'd9, 4'd2); step();
        idle_inputs(); set_issue(ADD, 5, 6, 0, 1'b0, 4'd0, 4'd3); step();
        idle_inputs(); set_issue(ADD, 7, 8, 0, 1'b0, 4'd0, 4'd4);
        flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h55;
        step();
        chk("flush_empty", 64'(is_empty_to_alu), 64'd1);
        chk("flush_full", 64'(full), 64'd0);
        idle_inputs();
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h66;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_flush%0d_empty", k), 64'(is_empty_to_alu), 64'd1);
        end

        // Async reset in the middle of a dispatch burst
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            set_issue(ADD, 32'(10 + k), 32'(20 + k), 0, 1'b0, 4'd0, 4'(8 + k));
            step();
        end
        chk("burst_active", 64'(is_empty_to_alu), 64'd0);
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_model();
        chk("async_rst_empty", 64'(is_empty_to_alu), 64'd1);
        chk("async_rst_op", 64'(op_to_alu), 64'd0);
        @(posedge clk);
        #1 compare_model();
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst%0d_empty", k), 64'(is_empty_to_alu), 64'd1);
        end

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            idle_inputs();
            if ($urandom_range(1, 0) == 1) begin
                set_issue(6'($urandom_range(63, 0)), $urandom(), $urandom(), $urandom(),
                          1'($urandom_range(1, 0)), 4'($urandom_range(7, 0)), 4'($urandom_range(15, 0)));
                issue_q2_busy = 1'($urandom_range(1, 0));
                issue_q2      = 4'($urandom_range(7, 0));
            end
            cdb_valid = ($urandom_range(9, 0) < 4);
            cdb_tag   = 4'($urandom_range(7, 0));
            cdb_data  = $urandom();
            flush     = ($urandom_range(49, 0) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
